// File: rtl/tlb_pkg.sv
// Shared encodings, entry layout and FSM state type for the TLB maintenance controller.
package tlb_pkg;

  localparam int unsigned TLB_ENTRY_W = 89;
  localparam logic [5:0]  ECODE_TLBR  = 6'h3F;
  localparam int unsigned PS_4K       = 12;
  localparam int unsigned PS_4M       = 21;
  localparam logic [4:0]  INVOP_MAX   = 5'd6;

  typedef enum logic [2:0] {
    OP_SRCH = 3'd0,
    OP_RD   = 3'd1,
    OP_WR   = 3'd2,
    OP_FILL = 3'd3,
    OP_INV  = 3'd4
  } tlb_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  // Bit offsets of the packed entry, MSB-first.
  localparam int unsigned E_OFF    = 88;
  localparam int unsigned VPPN_OFF = 69;
  localparam int unsigned PS_OFF   = 63;
  localparam int unsigned ASID_OFF = 53;
  localparam int unsigned G_OFF    = 52;
  localparam int unsigned PPN0_OFF = 32;
  localparam int unsigned PPN1_OFF = 6;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

endpackage

// File: rtl/tlb_csr_pack.sv
// Builds a packed TLB entry from the TLBEHI, TLBELO0/1, ASID and TLBIDX CSR values.
module tlb_csr_pack
  import tlb_pkg::*;
(
  input  logic [18:0]            ehi_vppn,
  input  logic [31:0]            elo0,
  input  logic [31:0]            elo1,
  input  logic [9:0]             asid,
  input  logic [5:0]             ps,
  input  logic                   ne,
  input  logic [5:0]             ecode,
  output logic [TLB_ENTRY_W-1:0] entry
);

  tlb_entry_t ent;
  logic       unused_elo;

  always_comb begin
    ent      = '0;
    // A refill exception always installs a valid entry regardless of NE.
    ent.e    = (ecode == ECODE_TLBR) ? 1'b1 : ~ne;
    ent.vppn = ehi_vppn;
    ent.ps   = ps;
    ent.asid = asid;
    ent.g    = elo0[6] & elo1[6];
    ent.ppn0 = elo0[27:8];
    ent.plv0 = elo0[3:2];
    ent.mat0 = elo0[5:4];
    ent.d0   = elo0[1];
    ent.v0   = elo0[0];
    ent.ppn1 = elo1[27:8];
    ent.plv1 = elo1[3:2];
    ent.mat1 = elo1[5:4];
    ent.d1   = elo1[1];
    ent.v1   = elo1[0];
  end

  assign entry      = ent;
  assign unused_elo = ^{elo0[31:28], elo0[7], elo1[31:28], elo1[7]};

endmodule

// File: rtl/tlb_ctrl.sv
// TLB maintenance initiator: serialises SRCH/RD/WR/FILL/INV requests through IDLE -> EXEC -> RESP.
module tlb_ctrl
  import tlb_pkg::*;
#(
  parameter int unsigned TLBNUM = 16,
  parameter int unsigned IDXW   = $clog2(TLBNUM)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [4:0]             req_invop,
  input  logic [9:0]             req_inv_asid,
  input  logic [18:0]            req_inv_vppn,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic                   resp_err,
  input  logic [IDXW-1:0]        csr_tlbidx_index,
  input  logic [5:0]             csr_tlbidx_ps,
  input  logic                   csr_tlbidx_ne,
  input  logic [18:0]            csr_tlbehi_vppn,
  input  logic [9:0]             csr_asid,
  input  logic [5:0]             csr_estat_ecode,
  input  logic [31:0]            csr_tlbelo0,
  input  logic [31:0]            csr_tlbelo1,
  output logic [2:0]             csr_we_tlbidx,
  output logic [IDXW-1:0]        csr_w_tlbidx_index,
  output logic                   csr_w_tlbidx_ne,
  output logic [5:0]             csr_w_tlbidx_ps,
  output logic                   csr_we_entry,
  output logic [TLB_ENTRY_W-1:0] csr_w_entry,
  output logic [18:0]            tlb_s_vppn,
  output logic [9:0]             tlb_s_asid,
  input  logic                   tlb_s_found,
  input  logic [IDXW-1:0]        tlb_s_index,
  output logic [IDXW-1:0]        tlb_r_index,
  input  logic [TLB_ENTRY_W-1:0] tlb_r_entry,
  output logic                   tlb_we,
  output logic [IDXW-1:0]        tlb_w_index,
  output logic [TLB_ENTRY_W-1:0] tlb_w_entry,
  output logic                   invtlb_valid,
  output logic [4:0]             invtlb_op
);

  state_e                 state, state_next;
  logic [2:0]             op_q;
  logic [4:0]             invop_q;
  logic [9:0]             inv_asid_q;
  logic [18:0]            inv_vppn_q;
  logic [IDXW-1:0]        fill_cnt;
  logic [TLB_ENTRY_W-1:0] pack_entry;
  logic                   op_err;

  tlb_csr_pack u_pack (
    .ehi_vppn (csr_tlbehi_vppn),
    .elo0     (csr_tlbelo0),
    .elo1     (csr_tlbelo1),
    .asid     (csr_asid),
    .ps       (csr_tlbidx_ps),
    .ne       (csr_tlbidx_ne),
    .ecode    (csr_estat_ecode),
    .entry    (pack_entry)
  );

  assign op_err = (op_q > OP_INV) || ((op_q == OP_INV) && (invop_q > INVOP_MAX));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      op_q       <= '0;
      invop_q    <= '0;
      inv_asid_q <= '0;
      inv_vppn_q <= '0;
      fill_cnt   <= '0;
    end else begin
      state    <= state_next;
      fill_cnt <= (fill_cnt == IDXW'(TLBNUM - 1)) ? '0 : fill_cnt + 1'b1;
      if (state == S_IDLE && req_valid) begin
        op_q       <= req_op;
        invop_q    <= req_invop;
        inv_asid_q <= req_inv_asid;
        inv_vppn_q <= req_inv_vppn;
      end
    end
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = ~reset;
        if (req_valid) state_next = S_EXEC;
      end
      S_EXEC: state_next = S_RESP;
      S_RESP: begin
        // Gated by reset so an abandoned operation never completes a handshake.
        resp_valid = ~reset;
        if (resp_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign resp_err = resp_valid & op_err;

  always_comb begin
    tlb_s_vppn         = csr_tlbehi_vppn;
    tlb_s_asid         = csr_asid;
    tlb_r_index        = csr_tlbidx_index;
    tlb_we             = 1'b0;
    tlb_w_index        = csr_tlbidx_index;
    tlb_w_entry        = pack_entry;
    invtlb_valid       = 1'b0;
    invtlb_op          = invop_q;
    csr_we_tlbidx      = '0;
    csr_w_tlbidx_index = csr_tlbidx_index;
    csr_w_tlbidx_ne    = 1'b0;
    csr_w_tlbidx_ps    = csr_tlbidx_ps;
    csr_we_entry       = 1'b0;
    csr_w_entry        = '0;
    if (state == S_EXEC && !op_err) begin
      case (op_q)
        OP_SRCH: begin
          if (tlb_s_found) begin
            csr_we_tlbidx      = 3'b011;
            csr_w_tlbidx_index = tlb_s_index;
          end else begin
            csr_we_tlbidx   = 3'b010;
            csr_w_tlbidx_ne = 1'b1;
          end
        end
        OP_RD: begin
          csr_we_tlbidx = 3'b110;
          csr_we_entry  = 1'b1;
          if (tlb_r_entry[E_OFF]) begin
            csr_w_tlbidx_ps = tlb_r_entry[PS_OFF +: 6];
            csr_w_entry     = tlb_r_entry;
          end else begin
            csr_w_tlbidx_ne = 1'b1;
            csr_w_tlbidx_ps = '0;
          end
        end
        OP_WR: tlb_we = 1'b1;
        OP_FILL: begin
          tlb_we      = 1'b1;
          tlb_w_index = fill_cnt;
        end
        OP_INV: begin
          invtlb_valid = 1'b1;
          tlb_s_asid   = inv_asid_q;
          tlb_s_vppn   = inv_vppn_q;
        end
        default: ;
      endcase
      if (reset) begin
        tlb_we        = 1'b0;
        invtlb_valid  = 1'b0;
        csr_we_tlbidx = '0;
        csr_we_entry  = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Randomised bench for tlb_ctrl: the bench acts as the TLB array and predicts every EXEC side effect.
module tb_tlb_ctrl;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;
  localparam int EW     = 89;

  logic            clk = 1'b0;
  logic            reset;
  logic            req_valid, req_ready;
  logic [2:0]      req_op;
  logic [4:0]      req_invop;
  logic [9:0]      req_inv_asid;
  logic [18:0]     req_inv_vppn;
  logic            resp_valid, resp_ready, resp_err;
  logic [IDXW-1:0] csr_tlbidx_index;
  logic [5:0]      csr_tlbidx_ps;
  logic            csr_tlbidx_ne;
  logic [18:0]     csr_tlbehi_vppn;
  logic [9:0]      csr_asid;
  logic [5:0]      csr_estat_ecode;
  logic [31:0]     csr_tlbelo0, csr_tlbelo1;
  logic [2:0]      csr_we_tlbidx;
  logic [IDXW-1:0] csr_w_tlbidx_index;
  logic            csr_w_tlbidx_ne;
  logic [5:0]      csr_w_tlbidx_ps;
  logic            csr_we_entry;
  logic [EW-1:0]   csr_w_entry;
  logic [18:0]     tlb_s_vppn;
  logic [9:0]      tlb_s_asid;
  logic            tlb_s_found;
  logic [IDXW-1:0] tlb_s_index;
  logic [IDXW-1:0] tlb_r_index;
  logic [EW-1:0]   tlb_r_entry;
  logic            tlb_we;
  logic [IDXW-1:0] tlb_w_index;
  logic [EW-1:0]   tlb_w_entry;
  logic            invtlb_valid;
  logic [4:0]      invtlb_op;

  tlb_ctrl #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_invop(req_invop),
    .req_inv_asid(req_inv_asid), .req_inv_vppn(req_inv_vppn),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err),
    .csr_tlbidx_index(csr_tlbidx_index), .csr_tlbidx_ps(csr_tlbidx_ps), .csr_tlbidx_ne(csr_tlbidx_ne),
    .csr_tlbehi_vppn(csr_tlbehi_vppn), .csr_asid(csr_asid), .csr_estat_ecode(csr_estat_ecode),
    .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1),
    .csr_we_tlbidx(csr_we_tlbidx), .csr_w_tlbidx_index(csr_w_tlbidx_index),
    .csr_w_tlbidx_ne(csr_w_tlbidx_ne), .csr_w_tlbidx_ps(csr_w_tlbidx_ps),
    .csr_we_entry(csr_we_entry), .csr_w_entry(csr_w_entry),
    .tlb_s_vppn(tlb_s_vppn), .tlb_s_asid(tlb_s_asid), .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
    .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
    .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
    .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] mem [TLBNUM];
  int            m_fill = 0;
  int            m_age  = -1;
  logic [2:0]    c_op;
  logic [4:0]    c_invop;
  logic [9:0]    c_asid;
  logic [18:0]   c_vppn;
  logic          m_err;

  int            seen_we_cnt, seen_inv_cnt, seen_pulse_cnt, seen_resp_cycles;
  logic [IDXW-1:0] seen_w_index, seen_idx;
  logic [EW-1:0] seen_w_entry, seen_entry;
  logic [2:0]    seen_we_tlbidx;
  logic          seen_ne, seen_we_entry, seen_err;
  logic [5:0]    seen_ps;
  logic [4:0]    seen_inv_op;
  logic [9:0]    seen_s_asid;
  logic [18:0]   seen_s_vppn;

  task automatic chk(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected handshake", name);
  endtask

  function automatic logic [EW-1:0] build(input logic [18:0] vppn, input logic [9:0] asid,
                                          input logic [5:0] ps, input logic ne, input logic [5:0] ecode,
                                          input logic [31:0] lo0, input logic [31:0] lo1);
    logic e;
    e = (ecode == 6'h3F) ? 1'b1 : !ne;
    return {e, vppn, ps, asid, lo0[6] & lo1[6],
            lo0[27:8], lo0[3:2], lo0[5:4], lo0[1], lo0[0],
            lo1[27:8], lo1[3:2], lo1[5:4], lo1[1], lo1[0]};
  endfunction

  // First (lowest-index) valid entry matching vppn at its page size and asid (or global).
  function automatic logic [4:0] lookup(input logic [18:0] v, input logic [9:0] a);
    logic [EW-1:0] t;
    logic [4:0]    r;
    logic          vm;
    r = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      t  = mem[i];
      vm = (t[68:63] == 6'd21) ? (t[87:78] == v[18:9]) : (t[87:69] == v);
      if (t[88] && vm && (t[52] || t[62:53] == a)) r = {1'b1, 4'(i)};
    end
    return r;
  endfunction

  // Bench-side TLB array ports respond once the DUT's request-side ports have settled.
  always @(posedge clk) begin
    #2;
    {tlb_s_found, tlb_s_index} = lookup(tlb_s_vppn, tlb_s_asid);
    tlb_r_entry = mem[tlb_r_index];
  end

  always @(posedge clk) m_fill <= reset ? 0 : (m_fill + 1) % TLBNUM;

  task automatic check_exec();
    logic [4:0]      r;
    logic [EW-1:0]   t;
    logic [IDXW-1:0] wi;
    case (c_op)
      3'd0: begin
        r = lookup(csr_tlbehi_vppn, csr_asid);
        chk("srch_s_vppn", tlb_s_vppn, csr_tlbehi_vppn);
        chk("srch_s_asid", tlb_s_asid, csr_asid);
        chk("srch_other_pulses", {tlb_we, invtlb_valid, csr_we_entry}, 0);
        if (r[4]) begin
          chk("srch_hit_we", csr_we_tlbidx, 3'b011);
          chk("srch_hit_index", csr_w_tlbidx_index, r[3:0]);
          chk("srch_hit_ne", csr_w_tlbidx_ne, 0);
        end else begin
          chk("srch_miss_we", csr_we_tlbidx, 3'b010);
          chk("srch_miss_ne", csr_w_tlbidx_ne, 1);
        end
      end
      3'd1: begin
        t = mem[csr_tlbidx_index];
        chk("rd_we_tlbidx", csr_we_tlbidx, 3'b110);
        chk("rd_we_entry", csr_we_entry, 1);
        chk("rd_other_pulses", {tlb_we, invtlb_valid}, 0);
        chk("rd_ne", csr_w_tlbidx_ne, !t[88]);
        chk("rd_ps", csr_w_tlbidx_ps, t[88] ? t[68:63] : 6'd0);
        chk("rd_entry", csr_w_entry, t[88] ? t : '0);
      end
      3'd2, 3'd3: begin
        t  = build(csr_tlbehi_vppn, csr_asid, csr_tlbidx_ps, csr_tlbidx_ne, csr_estat_ecode,
                   csr_tlbelo0, csr_tlbelo1);
        wi = (c_op == 3'd2) ? csr_tlbidx_index : 4'(m_fill);
        chk("wr_tlb_we", tlb_we, 1);
        chk("wr_other_pulses", {invtlb_valid, csr_we_tlbidx, csr_we_entry}, 0);
        chk("wr_w_index", tlb_w_index, wi);
        chk("wr_w_entry", tlb_w_entry, t);
        mem[wi] = t;
      end
      3'd4: begin
        if (c_invop <= 5'd6) begin
          chk("inv_valid", invtlb_valid, 1);
          chk("inv_op", invtlb_op, c_invop);
          chk("inv_s_asid", tlb_s_asid, c_asid);
          chk("inv_s_vppn", tlb_s_vppn, c_vppn);
          chk("inv_other_pulses", {tlb_we, csr_we_tlbidx, csr_we_entry}, 0);
        end else begin
          chk("inv_bad_pulses", {tlb_we, invtlb_valid, csr_we_tlbidx, csr_we_entry}, 0);
        end
      end
      default: chk("illegal_pulses", {tlb_we, invtlb_valid, csr_we_tlbidx, csr_we_entry}, 0);
    endcase
  endtask

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_pulses", {tlb_we, invtlb_valid, csr_we_tlbidx, csr_we_entry}, 0);
      m_age = -1;
      for (int i = 0; i < TLBNUM; i++) mem[i] = '0;
    end else begin
      if (tlb_we) begin seen_we_cnt++; seen_w_index = tlb_w_index; seen_w_entry = tlb_w_entry; end
      if (invtlb_valid) begin seen_inv_cnt++; seen_inv_op = invtlb_op; end
      if (tlb_we || invtlb_valid || csr_we_tlbidx != 3'b000 || csr_we_entry) seen_pulse_cnt++;
      if (m_age == 1) begin
        seen_we_tlbidx = csr_we_tlbidx; seen_idx = csr_w_tlbidx_index; seen_ne = csr_w_tlbidx_ne;
        seen_ps = csr_w_tlbidx_ps; seen_we_entry = csr_we_entry; seen_entry = csr_w_entry;
        seen_s_asid = tlb_s_asid; seen_s_vppn = tlb_s_vppn;
        check_exec();
      end else begin
        chk("idle_pulses", {tlb_we, invtlb_valid, csr_we_tlbidx, csr_we_entry}, 0);
      end
      chk("req_ready", req_ready, m_age < 0);
      chk("resp_valid", resp_valid, m_age >= 2);
      if (m_age >= 2) begin
        seen_resp_cycles++;
        seen_err = resp_err;
        chk("resp_err", resp_err, m_err);
      end
      if (m_age < 0) begin
        if (req_valid) begin
          c_op = req_op; c_invop = req_invop; c_asid = req_inv_asid; c_vppn = req_inv_vppn;
          m_err = (req_op > 3'd4) || (req_op == 3'd4 && req_invop > 5'd6);
          seen_we_cnt = 0; seen_inv_cnt = 0; seen_pulse_cnt = 0; seen_resp_cycles = 0;
          seen_err = 1'b0; seen_w_entry = '0; seen_w_index = '0;
          m_age = 1;
        end
      end else if (m_age >= 2 && resp_ready) begin
        m_age = -1;
      end else begin
        m_age++;
      end
    end
  end

  task automatic csr(input logic [3:0] idx, input logic [5:0] ps, input logic ne, input logic [18:0] vppn,
                     input logic [9:0] asid, input logic [5:0] ecode, input logic [31:0] lo0, input logic [31:0] lo1);
    csr_tlbidx_index = idx; csr_tlbidx_ps = ps; csr_tlbidx_ne = ne; csr_tlbehi_vppn = vppn;
    csr_asid = asid; csr_estat_ecode = ecode; csr_tlbelo0 = lo0; csr_tlbelo1 = lo1;
  endtask

  task automatic request(input logic [2:0] op, input logic [4:0] invop, input logic [9:0] ia,
                         input logic [18:0] iv, input int hold, input int fill_at);
    logic acc, got;
    @(posedge clk); #1;
    for (int n = 0; n < 40 && fill_at >= 0 && m_fill != fill_at; n++) begin @(posedge clk); #1; end
    req_op = op; req_invop = invop; req_inv_asid = ia; req_inv_vppn = iv;
    req_valid = 1'b1; resp_ready = 1'b0;
    acc = 1'b0;
    for (int n = 0; n < 20 && !acc; n++) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    if (!acc) begin fail_timeout("req_accept"); return; end
    repeat (1 + hold) begin @(posedge clk); #1; end
    resp_ready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk); got = resp_valid;
      @(posedge clk); #1;
    end
    resp_ready = 1'b0;
    if (!got) fail_timeout("resp_handshake");
  endtask

  logic [EW-1:0] wr_entry;
  logic [18:0]   vpool [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
    req_op = '0; req_invop = '0; req_inv_asid = '0; req_inv_vppn = '0;
    csr(4'd0, 6'd12, 1'b0, 19'd0, 10'd0, 6'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // WR to index 5
    csr(4'd5, 6'd12, 1'b0, 19'h12345, 10'h0A, 6'h00, 32'h0000_1053, 32'h0000_2043);
    request(3'd2, 5'd0, 10'd0, 19'd0, 0, -1);
    chk("wr5_we_count", seen_we_cnt, 1);
    chk("wr5_index", seen_w_index, 5);
    chk("wr5_e", seen_w_entry[88], 1);
    chk("wr5_g", seen_w_entry[52], 1);
    chk("wr5_ppn0", seen_w_entry[51:32], 20'h10);
    chk("wr5_ppn1", seen_w_entry[25:6], 20'h20);
    chk("wr5_mat0", seen_w_entry[29:28], 2'd1);
    chk("wr5_model", mem[5], seen_w_entry);
    wr_entry = seen_w_entry;

    // SRCH hit, global hit with another asid, then miss
    request(3'd0, 5'd0, 10'd0, 19'd0, 0, -1);
    chk("srch_we_lit", seen_we_tlbidx, 3'b011);
    chk("srch_idx_lit", seen_idx, 5);
    chk("srch_ne_lit", seen_ne, 0);
    csr_asid = 10'h0B;
    request(3'd0, 5'd0, 10'd0, 19'd0, 0, -1);
    chk("srch_g_we_lit", seen_we_tlbidx, 3'b011);
    chk("srch_g_idx_lit", seen_idx, 5);
    csr_asid = 10'h0A; csr_tlbehi_vppn = 19'h12346;
    request(3'd0, 5'd0, 10'd0, 19'd0, 0, -1);
    chk("srch_miss_we_lit", seen_we_tlbidx, 3'b010);
    chk("srch_miss_ne_lit", seen_ne, 1);

    // RD empty index 7, then index 5
    csr_tlbidx_index = 4'd7;
    request(3'd1, 5'd0, 10'd0, 19'd0, 0, -1);
    chk("rd7_ne", seen_ne, 1);
    chk("rd7_ps", seen_ps, 0);
    chk("rd7_we_entry", seen_we_entry, 1);
    chk("rd7_entry", seen_entry, 0);
    csr_tlbidx_index = 4'd5;
    request(3'd1, 5'd0, 10'd0, 19'd0, 0, -1);
    chk("rd5_ne", seen_ne, 0);
    chk("rd5_ps", seen_ps, 12);
    chk("rd5_entry", seen_entry, wr_entry);

    // FILL with EXEC at fill_cnt 9, refill ecode and then ordinary ecode
    csr(4'd0, 6'd12, 1'b1, 19'h00777, 10'h0A, 6'h3F, 32'h0000_3001, 32'h0000_4001);
    request(3'd3, 5'd0, 10'd0, 19'd0, 0, 8);
    chk("fill_index", seen_w_index, 9);
    chk("fill_e_tlbr", seen_w_entry[88], 1);
    csr_estat_ecode = 6'h00;
    request(3'd3, 5'd0, 10'd0, 19'd0, 0, 8);
    chk("fill_index2", seen_w_index, 9);
    chk("fill_e_ne", seen_w_entry[88], 0);

    // INVTLB legal and illegal, illegal opcode
    request(3'd4, 5'd5, 10'h0A, 19'h12345, 0, -1);
    chk("inv_cnt", seen_inv_cnt, 1);
    chk("inv_op_lit", seen_inv_op, 5);
    chk("inv_asid_lit", seen_s_asid, 10'h0A);
    chk("inv_vppn_lit", seen_s_vppn, 19'h12345);
    request(3'd4, 5'd9, 10'h0A, 19'h12345, 0, -1);
    chk("inv9_cnt", seen_inv_cnt, 0);
    chk("inv9_err", seen_err, 1);
    request(3'd6, 5'd0, 10'd0, 19'd0, 0, -1);
    chk("op6_err", seen_err, 1);
    chk("op6_pulses", seen_pulse_cnt, 0);

    // Back-pressure: resp_ready low for 4 cycles
    request(3'd0, 5'd0, 10'd0, 19'd0, 4, -1);
    chk("hold_resp_cycles", seen_resp_cycles, 5);

    // Reset during EXEC abandons the write
    csr(4'd3, 6'd12, 1'b0, 19'h00042, 10'h01, 6'h00, 32'h1, 32'h1);
    @(posedge clk); #1;
    req_op = 3'd2; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rstexec_we", seen_we_cnt, 0);
    chk("rstexec_resp", seen_resp_cycles, 0);

    vpool[0] = 19'h12345; vpool[1] = 19'h12346; vpool[2] = 19'h00100; vpool[3] = 19'h40000;
    for (int k = 0; k < 150; k++) begin
      int p;
      logic [2:0] op;
      p = int'($urandom_range(0, 9));
      case (p)
        0, 1: op = 3'd0;
        2, 9: op = 3'd1;
        3, 4: op = 3'd2;
        5:    op = 3'd3;
        6, 7: op = 3'd4;
        default: op = 3'(5 + $urandom_range(0, 2));
      endcase
      csr(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0) ? 6'd21 : 6'd12,
          1'($urandom_range(0, 3) == 0), vpool[$urandom_range(0, 3)] ^ 19'($urandom_range(0, 1)),
          10'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1) ? 6'h3F : 6'($urandom_range(0, 63)),
          $urandom, $urandom);
      request(op, 5'($urandom_range(0, 9)), 10'($urandom), 19'($urandom), int'($urandom_range(0, 3)), -1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
- Initiator side of the TLB maintenance interface. Executes TLBSRCH, TLBRD, TLBWR, TLBFILL and INVTLB requests from the pipeline's MEM stage.
- Drives the TLB write, read, invalidate and load/store search ports. Composes entries from the CSR values and writes results back to TLBIDX, TLBEHI, TLBELO0/1 and ASID.
- Serialises one request at a time, using a valid/ready handshake on both the request and response sides.

Parameters:
- TLBNUM, 16, number of TLB entries.
- IDXW, $clog2(TLBNUM), width of an entry index.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid / req_ready  in / out  1  request handshake
- req_op  in  3  0 SRCH, 1 RD, 2 WR, 3 FILL, 4 INV; values 5–7 are illegal
- req_invop  in  5  INVTLB op field
- req_inv_asid  in  10  INVTLB rj ASID
- req_inv_vppn  in  19  INVTLB rk VA[31:13]
- resp_valid / resp_ready  out / in  1  completion handshake
- resp_err  out  1  illegal op or INVTLB op greater than 6
- csr_tlbidx_index  in  IDXW;  csr_tlbidx_ps  in  6;  csr_tlbidx_ne  in  1
- csr_tlbehi_vppn  in  19;  csr_asid  in  10;  csr_estat_ecode  in  6
- csr_tlbelo0, csr_tlbelo1  in  32  layout: V[0] D[1] PLV[3:2] MAT[5:4] G[6] PPN[27:8]
- csr_we_tlbidx  out  3  per-field write enables {ps, ne, index}
- csr_w_tlbidx_index  out  IDXW;  csr_w_tlbidx_ne  out  1;  csr_w_tlbidx_ps  out  6
- csr_we_entry  out  1  write TLBEHI, TLBELO0/1 and ASID from csr_w_entry
- csr_w_entry  out  TLB_ENTRY_W  packed entry
- tlb_s_vppn  out  19;  tlb_s_asid  out  10;  tlb_s_found  in  1;  tlb_s_index  in  IDXW
- tlb_r_index  out  IDXW;  tlb_r_entry  in  TLB_ENTRY_W  packed read-port data
- tlb_we  out  1;  tlb_w_index  out  IDXW;  tlb_w_entry  out  TLB_ENTRY_W
- invtlb_valid  out  1;  invtlb_op  out  5

Behaviour:
- FSM states: IDLE, EXEC, RESP.
  - IDLE: req_ready=1. When req_valid is high, latch op, invop, asid and vppn, then go to EXEC.
  - EXEC lasts exactly one cycle, then go to RESP.
  - RESP: resp_valid=1 and is held until resp_ready, then return to IDLE.
- Latency: accept at cycle N, EXEC at N+1, resp_valid from N+2. A new request cannot be accepted earlier than N+3.
- All side-effect pulses are asserted only while state==EXEC and reset==0. The side-effect pulses are tlb_we, invtlb_valid, csr_we_tlbidx and csr_we_entry. Each is one cycle wide. tlb_we and invtlb_valid are never asserted together.
- CSR inputs are sampled combinationally during EXEC. The TLB search and read ports are combinational, so their results are consumed in the same EXEC cycle.
- fill_cnt: free-running IDXW-bit counter. It is 0 on reset, increments every cycle and wraps from TLBNUM-1 to 0.
- SRCH:
  - tlb_s_vppn=csr_tlbehi_vppn, tlb_s_asid=csr_asid.
  - Hit: csr_we_tlbidx=3'b011, index=tlb_s_index, ne=0.
  - Miss: csr_we_tlbidx=3'b010, ne=1; index and ps are unchanged.
- RD:
  - tlb_r_index=csr_tlbidx_index.
  - Entry e=1: csr_we_tlbidx=3'b110, ne=0, ps=entry.ps; csr_we_entry=1 with csr_w_entry=tlb_r_entry.
  - Entry e=0: ne=1, ps=0; csr_we_entry=1 with an all-zero entry.
- WR / FILL:
  - tlb_we=1. w_index is csr_tlbidx_index for WR and fill_cnt for FILL.
  - Entry fields: e = (ecode==ECODE_TLBR) ? 1 : ~csr_tlbidx_ne; vppn=csr_tlbehi_vppn; ps=csr_tlbidx_ps; asid=csr_asid; g = elo0.G & elo1.G.
  - Page fields: ppn/plv/mat/d/v for page 0 come from elo0 and for page 1 from elo1; ppn is taken as elo[27:8].
- INV:
  - invop 0–6: invtlb_valid=1, invtlb_op=invop, tlb_s_asid=req_inv_asid, tlb_s_vppn=req_inv_vppn.
  - invop above 6: no pulse, resp_err=1.
- Illegal req_op: EXEC produces no side effects; resp_err=1.
- When not in EXEC, the search port is driven with the SRCH values and no pulses are asserted.
- Reset values: state=IDLE, req_ready=0 during the reset cycle, resp_valid=0, resp_err=0, all pulses 0, latches 0, fill_cnt=0.
- Reset during EXEC or RESP: the operation is abandoned, no pulse is emitted in the reset cycle, and no response is produced.

Decomposition:
- tlb_pkg holds:
  - op encodings;
  - TLB_ENTRY_W=89 and its field offsets, MSB-first: e, vppn[19], ps[6], asid[10], g, ppn0[20], plv0, mat0, d0, v0, ppn1[20], plv1, mat1, d1, v1;
  - ECODE_TLBR=6'h3F;
  - PS_4K=12 and PS_4M=21.
- One combinational sub-module, tlb_csr_pack, builds the packed entry from EHI, ELO0/1, ASID, PS, NE and ecode.

Test Plan:
- WR: index=5, ne=0, ps=12, vppn=0x12345, asid=0x0A, elo0=0x0000_1053, elo1=0x0000_2043 -> single tlb_we at N+1 with w_index=5; entry e=1, g=1, ppn0=0x10, ppn1=0x20, mat0=1; resp_valid at N+2.
- SRCH after that WR with the same vppn and asid -> csr_we_tlbidx=3'b011, index=5, ne=0. With asid=0x0B and g=1 -> still a hit. With vppn=0x12346 -> we=3'b010, ne=1.
- RD of an empty index 7 -> ne=1, ps=0, csr_we_entry=1 with zero entry. RD of index 5 -> ne=0, ps=12, entry equal to the WR entry.
- FILL with ne=1, ecode=0x3F, EXEC when fill_cnt=9 -> w_index=9 and e=1. Same FILL with ecode=0 -> e=0.
- INV invop=5, asid=0x0A, vppn=0x12345 -> invtlb_valid pulse with invtlb_op=5 and matching s port. invop=9 -> no pulse, resp_err=1. req_op=6 -> resp_err=1, no side effects.
- resp_ready held low for 4 cycles -> resp_valid held and req_ready=0. Reset asserted during EXEC -> no tlb_we, state IDLE, resp_valid=0.
